apod_sum: RTL and testbench
===========================

# apod_sum

Apodized delay-and-sum stage, fed by the per-channel delay stage and sitting directly downstream of it in the beamforming path. It accepts one frame of NUM_CHANNELS delayed samples, multiplies each channel by a programmable unsigned apodization weight, and accumulates serially, one channel per clock. It then emits one scaled, beamformed sample per frame through a valid/ready handshake.

## Interface
- DATA_WIDTH, 16, width of each signed channel sample and of dout
- NUM_CHANNELS, 16, channels per frame; power of two, ≥2
- WEIGHT_WIDTH, 8, unsigned apodization weight width
- Derived: CW = $clog2(NUM_CHANNELS); SHIFT = WEIGHT_WIDTH + CW; ACC_WIDTH = DATA_WIDTH + WEIGHT_WIDTH + CW + 1
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- din_flat  in  NUM_CHANNELS*DATA_WIDTH  signed samples; channel i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- in_valid  in  1  din_flat holds a frame
- in_ready  out  1  block can accept a frame
- weight_we  in  1  weight write strobe
- weight_addr  in  CW  channel index of the write
- weight_data  in  WEIGHT_WIDTH  unsigned weight
- dout  out  DATA_WIDTH  signed beamformed sample
- out_valid  out  1  dout valid
- out_ready  in  1  consumer accepts dout
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCUM, OUTPUT.
- IDLE: in_ready = 1. On in_valid & in_ready at a rising edge:
  - latch all of din_flat into per-channel sample registers
  - clear acc and channel counter ch
  - go to ACCUM
- ACCUM: each cycle, acc += sample[ch] * weight[ch], with the sample signed, the weight zero-extended, and the product sign-extended to ACC_WIDTH.
  - ch increments each cycle.
  - On the cycle with ch == NUM_CHANNELS-1, the final sum (acc + last product) is arithmetically right-shifted by SHIFT, truncated toward −∞, and registered into dout. State goes to OUTPUT.
  - No saturation is needed: |result| ≤ 2^(DATA_WIDTH-1) by construction.
- OUTPUT: out_valid = 1; dout is held stable. On out_ready, go to IDLE and drop out_valid.
- in_ready = 1 only in IDLE. Frames offered outside IDLE are not taken, and the upstream stage holds them.
- Weights are NUM_CHANNELS registers, reset to 2^WEIGHT_WIDTH − 1. They are written only in IDLE.
  - weight_we in ACCUM or OUTPUT is ignored.
  - A write in IDLE coinciding with a frame accept is applied, and the accepted frame uses the new weight.
- busy = (state != IDLE).

## Timing
- Reset (asynchronous assert, synchronous-safe deassert is upstream's responsibility):
  - state IDLE, acc 0, ch 0, dout 0, out_valid 0, busy 0, weights all-ones
  - in_ready forced 0 while reset is low
- Latency: for a frame accepted at edge E0, ACCUM runs edges E1..EN. out_valid rises after edge E(NUM_CHANNELS) and is visible in the following cycle.
- Minimum frame period: NUM_CHANNELS + 2 cycles (accept, N accumulate, output handshake, then IDLE).
- out_valid, once high, stays high with dout constant until out_ready is sampled high.
- Reset asserted mid-ACCUM or mid-OUTPUT aborts the frame immediately. No partial output is produced, and weights revert to all-ones.
- Sample registers and acc are not observable outside the block. Only dout, out_valid, in_ready and busy are checked.

## Test plan
- Defaults after reset, all 16 channels = 1000, out_ready = 1 -> dout = 996 (16·1000·255 = 4 080 000, >>12); out_valid exactly 16 cycles after accept.
- Write weights: all 0 except ch3 = 128; ch3 = −4096, others 32767 -> dout = −128.
- Extremes, weights 255: all −32768 -> dout = −32640; all 32767 -> dout = 32639; odd negative truncation: all −1 -> dout = −1.
- Backpressure: hold out_ready = 0 for 5 cycles in OUTPUT while pulsing weight_we and in_valid. Required:
  - dout and out_valid stable
  - in_ready = 0
  - write ignored (next frame uses old weight)
  - after handshake, one IDLE cycle, then next frame accepted
- Reset pulse at the 7th ACCUM cycle -> out_valid, dout, busy = 0 at once; in_ready = 0 during reset and 1 after release. A following frame of all 1000 -> 996 (weights restored).
- Back-to-back frames with in_valid and out_ready held high -> accepts spaced exactly 18 cycles apart; each dout matches its own frame.

Source files
------------

// File: rtl/apod_sum_if.sv
// Frame, weight-write and result handshake bundle for apod_sum.
interface apod_sum_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 16,
    parameter int WEIGHT_WIDTH = 8
);
    localparam int CW = $clog2(NUM_CHANNELS);

    logic [NUM_CHANNELS*DATA_WIDTH-1:0] din_flat;
    logic                               in_valid;
    logic                               in_ready;
    logic                               weight_we;
    logic [CW-1:0]                      weight_addr;
    logic [WEIGHT_WIDTH-1:0]            weight_data;
    logic [DATA_WIDTH-1:0]              dout;
    logic                               out_valid;
    logic                               out_ready;

    modport master (
        output din_flat, in_valid, weight_we, weight_addr, weight_data, out_ready,
        input  in_ready, dout, out_valid
    );

    modport slave (
        input  din_flat, in_valid, weight_we, weight_addr, weight_data, out_ready,
        output in_ready, dout, out_valid
    );
endinterface

// File: rtl/apod_sum.sv
// Apodized delay-and-sum: latches one frame, weights each channel, sums
// serially one channel per clock and emits one scaled sample per frame.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a frame; weight writes accepted
// ACCUM  | acc += sample[ch] * weight[ch], one channel per cycle
// OUTPUT | dout held with out_valid high until out_ready
module apod_sum #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 16,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    apod_sum_if.slave  bus,
    output logic       busy
);
    localparam int CW        = $clog2(NUM_CHANNELS);
    localparam int SHIFT     = WEIGHT_WIDTH + CW;
    localparam int ACC_WIDTH = DATA_WIDTH + WEIGHT_WIDTH + CW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 ch_q, ch_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]         dout_q, dout_d;
    logic [DATA_WIDTH-1:0]         samp_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]         samp_d [NUM_CHANNELS];
    logic [WEIGHT_WIDTH-1:0]       wt_q   [NUM_CHANNELS];
    logic [WEIGHT_WIDTH-1:0]       wt_d   [NUM_CHANNELS];

    logic [DATA_WIDTH-1:0]         cur_samp;
    logic [WEIGHT_WIDTH-1:0]       cur_wt;
    logic signed [ACC_WIDTH-1:0]   samp_ext;
    logic signed [ACC_WIDTH-1:0]   wt_ext;
    logic signed [ACC_WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0]   sum;

    // Current channel's weighted term; the product fits ACC_WIDTH exactly,
    // so the truncated full-width multiply yields the exact signed product.
    always_comb begin
        cur_samp = samp_q[ch_q];
        cur_wt   = wt_q[ch_q];
        samp_ext = {{(ACC_WIDTH-DATA_WIDTH){cur_samp[DATA_WIDTH-1]}}, cur_samp};
        wt_ext   = {{(ACC_WIDTH-WEIGHT_WIDTH){1'b0}}, cur_wt};
        prod     = samp_ext * wt_ext;
        sum      = acc_q + prod;
    end

    // Next-state logic for the sequencer, datapath registers and weights.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        samp_d  = samp_q;
        wt_d    = wt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.weight_we) begin
                    wt_d[bus.weight_addr] = bus.weight_data;
                end
                if (bus.in_valid) begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        samp_d[i] = bus.din_flat[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH];
                    end
                    acc_d   = '0;
                    ch_d    = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = sum;
                ch_d  = ch_q + CW'(1);
                if (ch_q == CW'(NUM_CHANNELS-1)) begin
                    // Bit-select of the sum is the arithmetic shift, floored.
                    dout_d  = sum[SHIFT +: DATA_WIDTH];
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                samp_q[i] <= '0;
                wt_q[i]   <= '1;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            samp_q  <= samp_d;
            wt_q    <= wt_d;
        end
    end

    // Handshake outputs decoded from the state; in_ready is gated by reset.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && reset;
        bus.out_valid = (state_q == OUTPUT);
        bus.dout      = dout_q;
        busy          = (state_q != IDLE);
    end
endmodule

// File: tb/tb_apod_sum.sv
// Self-checking bench for apod_sum against a frame-level arithmetic model.
module tb_apod_sum;
    localparam int DW = 16;
    localparam int NC = 16;
    localparam int WW = 8;
    localparam int CW = $clog2(NC);
    localparam longint DIV = longint'(1) << (WW + CW);

    typedef int frame_t [NC];

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    int   errors = 0;
    int   checks = 0;
    int   model_w [NC];

    apod_sum_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .WEIGHT_WIDTH(WW)) bus ();

    apod_sum #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .WEIGHT_WIDTH(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Weighted sum of the frame divided by 2^SHIFT, rounded toward -inf.
    function automatic int model(input frame_t s);
        longint acc = 0;
        longint q;
        for (int i = 0; i < NC; i++) acc += longint'(s[i]) * longint'(model_w[i]);
        q = acc / DIV;
        if (acc < 0 && (acc % DIV) != 0) q = q - 1;
        return int'(q);
    endfunction

    function automatic frame_t const_frame(input int v);
        frame_t f;
        for (int i = 0; i < NC; i++) f[i] = v;
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < NC; i++) f[i] = int'($urandom_range(0, 65535)) - 32768;
        return f;
    endfunction

    task automatic drive_din(input frame_t s);
        for (int i = 0; i < NC; i++) bus.din_flat[(i+1)*DW-1 -: DW] = DW'(s[i]);
    endtask

    // Called at a negedge while IDLE; returns at the negedge after the write.
    task automatic write_weight(input int addr, input int data);
        bus.weight_we   = 1'b1;
        bus.weight_addr = CW'(addr);
        bus.weight_data = WW'(data);
        @(negedge clk);
        bus.weight_we   = 1'b0;
        model_w[addr]   = data;
    endtask

    // Offers a frame, waits for out_valid; returns at the negedge where it is seen.
    task automatic do_frame(input frame_t s, output int lat, output logic [DW-1:0] d,
                            output bit to);
        drive_din(s);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        to = !bus.out_valid;
        d  = bus.dout;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (bus.dout !== 16'd0) begin errors++; $display("FAIL reset_dout got=%0d want=0", $signed(bus.dout)); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b want=1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic frame_check(input string name, input frame_t s, input int exp);
        int lat; logic [DW-1:0] d; bit to;
        do_frame(s, lat, d, to);
        checks++; if (to) begin errors++; $display("FAIL %s_timeout got=no out_valid want=out_valid", name); end
        checks++; if (lat != NC) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, NC); end
        checks++; if (d !== DW'(exp)) begin errors++; $display("FAIL %s_dout got=%0d want=%0d", name, $signed(d), exp); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_return_idle got=ov%b busy%b want=0 0", name, bus.out_valid, busy); end
    endtask

    task automatic test_default();
        frame_check("default", const_frame(1000), 996);
    endtask

    task automatic test_weights();
        frame_t f;
        for (int i = 0; i < NC; i++) write_weight(i, (i == 3) ? 128 : 0);
        f = const_frame(32767);
        f[3] = -4096;
        frame_check("weights", f, -128);
    endtask

    task automatic test_extremes();
        for (int i = 0; i < NC; i++) write_weight(i, 255);
        frame_check("min", const_frame(-32768), -32640);
        frame_check("max", const_frame(32767), 32639);
        frame_check("neg1", const_frame(-1), -1);
    endtask

    task automatic test_random();
        frame_t f;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NC; i++) write_weight(i, int'($urandom_range(0, 255)));
            f = rand_frame();
            frame_check("random", f, model(f));
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [DW-1:0] d0, d; bit to;
        frame_t f1, f2;
        f1 = rand_frame();
        f2 = rand_frame();
        bus.out_ready = 1'b0;
        do_frame(f1, lat, d0, to);
        checks++; if (to || d0 !== DW'(model(f1))) begin errors++; $display("FAIL bp_first_dout got=%0d want=%0d", $signed(d0), model(f1)); end
        for (int k = 0; k < 5; k++) begin
            bus.weight_we   = 1'b1;
            bus.weight_addr = '0;
            bus.weight_data = WW'(model_w[0] ^ 8'h5a);
            drive_din(f2);
            bus.in_valid    = 1'b1;
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1 || bus.dout !== d0) begin errors++; $display("FAIL bp_hold got=ov%b dout%0d want=ov1 dout%0d", bus.out_valid, $signed(bus.dout), $signed(d0)); end
            checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_not_ready got=rdy%b busy%b want=rdy0 busy1", bus.in_ready, busy); end
        end
        bus.weight_we = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle_gap got=ov%b rdy%b busy%b want=0 1 0", bus.out_valid, bus.in_ready, busy); end
        do_frame(f2, lat, d, to);
        checks++; if (to || lat != NC) begin errors++; $display("FAIL bp_next_latency got=%0d want=%0d", lat, NC); end
        checks++; if (d !== DW'(model(f2))) begin errors++; $display("FAIL bp_old_weight got=%0d want=%0d", $signed(d), model(f2)); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_din(const_frame(1000));
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.dout !== 16'd0) begin errors++; $display("FAIL midreset_clear got=ov%b busy%b dout%0d want=0 0 0", bus.out_valid, busy, $signed(bus.dout)); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got=%b want=0", bus.in_ready); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NC; i++) model_w[i] = 255;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_release got=%b want=1", bus.in_ready); end
        @(negedge clk);
        frame_check("after_reset", const_frame(1000), 996);
    endtask

    task automatic test_back_to_back();
        frame_t s;
        int expq [$];
        int acc_at [4];
        int n_acc = 0;
        int n_out = 0;
        int e;
        bit acc_now;
        s = rand_frame();
        drive_din(s);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 200 && n_out < 4; c++) begin
            if (bus.out_valid) begin
                e = (expq.size() > 0) ? expq.pop_front() : 99999;
                checks++; if (bus.dout !== DW'(e)) begin errors++; $display("FAIL b2b_dout got=%0d want=%0d", $signed(bus.dout), e); end
                n_out++;
            end
            acc_now = bus.in_ready && bus.in_valid;
            @(posedge clk);
            @(negedge clk);
            if (acc_now) begin
                acc_at[n_acc] = c;
                expq.push_back(model(s));
                n_acc++;
                s = rand_frame();
                drive_din(s);
                if (n_acc == 4) bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (n_out != 4) begin errors++; $display("FAIL b2b_count got=%0d want=4", n_out); end
        for (int k = 1; k < n_acc; k++) begin
            checks++; if (acc_at[k] - acc_at[k-1] != NC + 2) begin errors++; $display("FAIL b2b_spacing got=%0d want=%0d", acc_at[k] - acc_at[k-1], NC + 2); end
        end
    endtask

    initial begin
        bus.din_flat    = '0;
        bus.in_valid    = 1'b0;
        bus.weight_we   = 1'b0;
        bus.weight_addr = '0;
        bus.weight_data = '0;
        bus.out_ready   = 1'b1;
        for (int i = 0; i < NC; i++) model_w[i] = 255;
        test_reset();
        test_default();
        test_weights();
        test_extremes();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
